// File: rtl/irq_prio_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// irq_prio_sync : per-source edge/level interrupt latch with CPU ack and a
//                 strobe-registered active-low 68k IPL code plus winning index.
// Rev 1.0
// ---------------------------------------------------------------------------
module irq_prio_sync #(
    parameter int                 NUM_IRQ    = 3,
    parameter int                 IPL_W      = 3,
    parameter logic [NUM_IRQ-1:0] LEVEL_MASK = '0,
    localparam int                VEC_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               CLK_EN,
    input  logic [NUM_IRQ-1:0] IRQ_IN,
    input  logic [NUM_IRQ-1:0] IRQ_EN,
    input  logic               WR_ACK,
    input  logic [NUM_IRQ-1:0] ACK_BITS,
    output logic [NUM_IRQ-1:0] PENDING,
    output logic [IPL_W-1:0]   IPL_N,
    output logic [VEC_W-1:0]   VECTOR
);

    generate
        if (((2 ** IPL_W) - 1) < NUM_IRQ) begin : g_param_check
            $error("irq_prio_sync: IPL_W too narrow for NUM_IRQ");
        end
    endgenerate

    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [NUM_IRQ-1:0] pending_d;
    logic [IPL_W-1:0]   ipl_n_q;
    logic [VEC_W-1:0]   vector_q;

    logic [NUM_IRQ-1:0] set_w;
    logic [NUM_IRQ-1:0] clr_w;
    logic [IPL_W-1:0]   level_w;
    logic [VEC_W-1:0]   win_w;

    always_comb begin
        set_w = (LEVEL_MASK & IRQ_IN & IRQ_EN) |
                (~LEVEL_MASK & IRQ_IN & ~prev_q & IRQ_EN);
        clr_w = {NUM_IRQ{WR_ACK}} & ACK_BITS;
    end

    // Disable beats set, and set beats ack so a coincident event is not lost.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (!IRQ_EN[i]) begin
                pending_d[i] = 1'b0;
            end else if (set_w[i]) begin
                pending_d[i] = 1'b1;
            end else if (clr_w[i]) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    // Walk from the lowest priority upward so the lowest pending index wins.
    always_comb begin
        level_w = '0;
        win_w   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                level_w = IPL_W'(NUM_IRQ - i);
                win_w   = VEC_W'(i);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev_q    <= IRQ_IN;
            pending_q <= '0;
            ipl_n_q   <= '1;
            vector_q  <= '0;
        end else begin
            prev_q    <= IRQ_IN;
            pending_q <= pending_d;
            if (CLK_EN) begin
                ipl_n_q  <= ~level_w;
                vector_q <= win_w;
            end
        end
    end

    assign PENDING = pending_q;
    assign IPL_N   = ipl_n_q;
    assign VECTOR  = vector_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_prio_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_irq_prio_sync : directed checks on edge-mode, mixed level/edge and
//                    seven-source instances of irq_prio_sync.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_irq_prio_sync;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;

    logic [2:0] a_irq, a_en, a_bits;
    logic       a_ack;
    logic [2:0] a_pend, a_ipl;
    logic [1:0] a_vec;

    logic [2:0] b_irq, b_en, b_bits;
    logic       b_ack;
    logic [2:0] b_pend, b_ipl;
    logic [1:0] b_vec;

    logic [6:0] c_irq, c_en, c_bits;
    logic       c_ack;
    logic [6:0] c_pend;
    logic [2:0] c_ipl;
    logic [2:0] c_vec;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    irq_prio_sync #(.NUM_IRQ(3), .IPL_W(3), .LEVEL_MASK(3'b000)) u_edge (
        .CLK(clk), .RESET(rst), .CLK_EN(clk_en), .IRQ_IN(a_irq), .IRQ_EN(a_en),
        .WR_ACK(a_ack), .ACK_BITS(a_bits), .PENDING(a_pend), .IPL_N(a_ipl), .VECTOR(a_vec)
    );

    irq_prio_sync #(.NUM_IRQ(3), .IPL_W(3), .LEVEL_MASK(3'b010)) u_lvl (
        .CLK(clk), .RESET(rst), .CLK_EN(clk_en), .IRQ_IN(b_irq), .IRQ_EN(b_en),
        .WR_ACK(b_ack), .ACK_BITS(b_bits), .PENDING(b_pend), .IPL_N(b_ipl), .VECTOR(b_vec)
    );

    irq_prio_sync #(.NUM_IRQ(7), .IPL_W(3), .LEVEL_MASK(7'b0000000)) u_seven (
        .CLK(clk), .RESET(rst), .CLK_EN(clk_en), .IRQ_IN(c_irq), .IRQ_EN(c_en),
        .WR_ACK(c_ack), .ACK_BITS(c_bits), .PENDING(c_pend), .IPL_N(c_ipl), .VECTOR(c_vec)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        clk_en = 1'b1;
        a_irq = 3'b111; a_en = 3'b111; a_ack = 1'b0; a_bits = 3'b000;
        b_irq = 3'b000; b_en = 3'b111; b_ack = 1'b0; b_bits = 3'b000;
        c_irq = 7'h00;  c_en = 7'h7F;  c_ack = 1'b0; c_bits = 7'h00;

        // ---- edge-mode instance ----
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_pend", 32'(a_pend), 32'h0);
        chk("rst_ipl",  32'(a_ipl),  32'h7);
        chk("rst_vec",  32'(a_vec),  32'h0);
        tick();
        chk("no_spurious_pend", 32'(a_pend), 32'h0);
        chk("no_spurious_ipl",  32'(a_ipl),  32'h7);
        a_irq = 3'b000;
        tick();
        chk("fall_no_set", 32'(a_pend), 32'h0);

        a_irq = 3'b100;
        tick();
        chk("src2_pend", 32'(a_pend), 32'h4);
        a_irq = 3'b000;
        tick();
        chk("src2_ipl", 32'(a_ipl), 32'h6);
        chk("src2_vec", 32'(a_vec), 32'h2);

        a_irq = 3'b010;
        tick();
        chk("src1_pend", 32'(a_pend), 32'h6);
        a_irq = 3'b000;
        tick();
        chk("src1_ipl", 32'(a_ipl), 32'h5);
        chk("src1_vec", 32'(a_vec), 32'h1);

        a_ack = 1'b1; a_bits = 3'b010;
        tick();
        chk("ack1_pend", 32'(a_pend), 32'h4);
        a_ack = 1'b0; a_bits = 3'b000;
        tick();
        chk("ack1_ipl", 32'(a_ipl), 32'h6);
        chk("ack1_vec", 32'(a_vec), 32'h2);

        a_irq = 3'b001; a_ack = 1'b1; a_bits = 3'b001;
        tick();
        chk("setwins_pend", 32'(a_pend), 32'h5);
        a_irq = 3'b000; a_ack = 1'b0; a_bits = 3'b000;
        tick();
        chk("setwins_ipl", 32'(a_ipl), 32'h4);
        chk("setwins_vec", 32'(a_vec), 32'h0);

        a_ack = 1'b1; a_bits = 3'b111;
        tick();
        chk("ackall_pend", 32'(a_pend), 32'h0);
        a_ack = 1'b0; a_bits = 3'b000;
        tick();
        chk("ackall_ipl", 32'(a_ipl), 32'h7);

        a_irq = 3'b100;
        tick();
        a_irq = 3'b000; a_bits = 3'b100;
        tick();
        chk("noack_hold_pend", 32'(a_pend), 32'h4);
        chk("noack_hold_ipl",  32'(a_ipl),  32'h6);
        a_bits = 3'b000; a_en = 3'b011;
        tick();
        chk("disable_pend", 32'(a_pend), 32'h0);
        tick();
        chk("disable_ipl", 32'(a_ipl), 32'h7);
        a_en = 3'b111;

        clk_en = 1'b0;
        a_irq = 3'b010;
        tick();
        a_irq = 3'b000;
        tick(); tick();
        chk("sparse_pend", 32'(a_pend), 32'h2);
        chk("sparse_hold_ipl", 32'(a_ipl), 32'h7);
        clk_en = 1'b1;
        tick();
        chk("sparse_strobe_ipl", 32'(a_ipl), 32'h5);
        clk_en = 1'b0;
        a_ack = 1'b1; a_bits = 3'b010;
        tick();
        a_ack = 1'b0; a_bits = 3'b000; a_irq = 3'b100;
        tick();
        a_irq = 3'b000; a_ack = 1'b1; a_bits = 3'b100;
        tick();
        a_ack = 1'b0; a_bits = 3'b000;
        chk("hidden_pulse_pend", 32'(a_pend), 32'h0);
        chk("hidden_pulse_ipl_hold", 32'(a_ipl), 32'h5);
        clk_en = 1'b1;
        tick();
        chk("hidden_pulse_ipl", 32'(a_ipl), 32'h7);

        a_irq = 3'b001;
        tick();
        a_irq = 3'b000;
        tick();
        chk("pre_rst_ipl", 32'(a_ipl), 32'h4);
        clk_en = 1'b0; rst = 1'b1;
        tick();
        chk("midrst_ipl",  32'(a_ipl),  32'h7);
        chk("midrst_vec",  32'(a_vec),  32'h0);
        chk("midrst_pend", 32'(a_pend), 32'h0);
        rst = 1'b0; clk_en = 1'b1;

        // ---- mixed level/edge instance ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b_irq = 3'b010;
        tick();
        chk("lvl_pend", 32'(b_pend), 32'h2);
        tick();
        chk("lvl_ipl", 32'(b_ipl), 32'h5);
        chk("lvl_vec", 32'(b_vec), 32'h1);
        b_ack = 1'b1; b_bits = 3'b010;
        tick();
        chk("lvl_ack_high_pend", 32'(b_pend), 32'h2);
        b_ack = 1'b0; b_bits = 3'b000; b_irq = 3'b000;
        tick();
        chk("lvl_drop_hold", 32'(b_pend), 32'h2);
        b_ack = 1'b1; b_bits = 3'b010;
        tick();
        chk("lvl_ack_low_pend", 32'(b_pend), 32'h0);
        b_ack = 1'b0; b_bits = 3'b000;
        tick();
        chk("lvl_ack_low_ipl", 32'(b_ipl), 32'h7);
        b_irq = 3'b001;
        tick();
        chk("edge_hi_pend", 32'(b_pend), 32'h1);
        b_ack = 1'b1; b_bits = 3'b001;
        tick();
        chk("edge_no_refire", 32'(b_pend), 32'h0);
        b_ack = 1'b0; b_bits = 3'b000; b_irq = 3'b000;

        // ---- seven-source instance ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        c_irq = 7'h7F;
        tick();
        chk("c_all_pend", 32'(c_pend), 32'h7F);
        c_irq = 7'h00;
        tick();
        chk("c_all_ipl", 32'(c_ipl), 32'h0);
        chk("c_all_vec", 32'(c_vec), 32'h0);
        c_ack = 1'b1; c_bits = 7'h01;
        tick();
        chk("c_ack0_pend", 32'(c_pend), 32'h7E);
        c_ack = 1'b0; c_bits = 7'h00;
        tick();
        chk("c_ack0_ipl", 32'(c_ipl), 32'h1);
        chk("c_ack0_vec", 32'(c_vec), 32'h1);
        c_ack = 1'b1; c_bits = 7'h3F;
        tick();
        c_ack = 1'b0; c_bits = 7'h00;
        tick();
        chk("c_src6_ipl", 32'(c_ipl), 32'h6);
        chk("c_src6_vec", 32'(c_vec), 32'h6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
